// File: rtl/vscale_fetch_queue.sv
// rtl/vscale_fetch_queue.sv - vscale fetch front end: sequential PC generation, imem port, DEPTH-entry instruction queue
// At most one data phase is outstanding; queue space is reserved for it before the address is issued.
module vscale_fetch_queue #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0200,
  parameter logic [XLEN-1:0]  NOP_INST = 32'h0000_0013
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  output logic                      imem_req,
  output logic [XLEN-1:0]           imem_addr,
  input  logic                      imem_wait,
  input  logic [XLEN-1:0]           imem_rdata,
  input  logic                      redirect,
  input  logic [XLEN-1:0]           redirect_pc,
  input  logic                      stall_DX,
  output logic                      valid_DX,
  output logic [XLEN-1:0]           inst_DX,
  output logic [XLEN-1:0]           PC_DX,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

  logic [XLEN-1:0] r_pc_mem   [DEPTH];
  logic [XLEN-1:0] r_inst_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_pend_pc;
  logic            r_outstanding;
  logic            r_discard;

  logic [CW:0]     w_credit;
  logic            w_accept;
  logic            w_done;
  logic            w_push;
  logic            w_pop;
  logic            w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^redirect_pc[1:0];

  // Credit uses the pre-pop count, so a same-cycle pop never enables an issue.
  assign w_credit  = {1'b0, r_count} + {{CW{1'b0}}, r_outstanding};
  assign imem_req  = hresetn && !redirect && (w_credit < LP_DEPTH);
  assign imem_addr = r_fetch_pc;

  assign w_accept = imem_req && !imem_wait;
  assign w_done   = r_outstanding && !imem_wait;
  assign w_push   = w_done && !r_discard && !redirect;
  assign w_pop    = valid_DX && !stall_DX;

  assign valid_DX = (r_count != '0);
  assign inst_DX  = valid_DX ? r_inst_mem[r_rd_ptr] : NOP_INST;
  assign PC_DX    = valid_DX ? r_pc_mem[r_rd_ptr]   : '0;
  assign count    = r_count;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_fetch_pc    <= RESET_PC;
      r_pend_pc     <= '0;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
    end else begin
      if (redirect)
        r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (w_accept)
        r_fetch_pc <= r_fetch_pc + XLEN'(4);

      if (w_accept) begin
        r_pend_pc     <= r_fetch_pc;
        r_outstanding <= 1'b1;
      end else if (w_done) begin
        r_outstanding <= 1'b0;
      end

      // A response still in flight at redirect belongs to the old stream.
      if (redirect && r_outstanding && !w_done)
        r_discard <= 1'b1;
      else if (w_done)
        r_discard <= 1'b0;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge hclk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_pend_pc;
      r_inst_mem[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_vscale_fetch_queue.sv
// tb/tb_vscale_fetch_queue.sv - scoreboard bench for vscale_fetch_queue
// The imem slave answers each address with a fixed function of it; the scoreboard tracks expected queue contents.
module tb_vscale_fetch_queue;

  logic        hclk;
  logic        hresetn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_wait;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall_DX;
  logic        valid_DX;
  logic [31:0] inst_DX;
  logic [31:0] PC_DX;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_q [$];
  logic [31:0] acc_log [$];
  logic [31:0] m_pc;
  logic [31:0] m_pend_addr;
  bit          m_pend;
  bit          m_disc;

  vscale_fetch_queue #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0200), .NOP_INST(32'h0000_0013)
  ) dut (
    .hclk(hclk), .hresetn(hresetn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wait(imem_wait), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stall_DX(stall_DX), .valid_DX(valid_DX), .inst_DX(inst_DX), .PC_DX(PC_DX), .count(count)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ 32'hC3C3_3C3C;
  endfunction

  // One clock: present slave data, score what the edge will do, then advance past the edge.
  task automatic cycle();
    bit          exp_req;
    bit          done;
    bit          acc;
    logic [63:0] head;
    imem_rdata = m_pend ? rdata_of(m_pend_addr) : 32'hDEAD_BEEF;
    #1;
    if (!hresetn) begin
      n_cmp++;
      if (imem_req !== 1'b0 || valid_DX !== 1'b0 || count !== 3'd0 ||
          inst_DX !== 32'h0000_0013 || PC_DX !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_outputs: got req=%b valid=%b count=%0d inst=%h pc=%h, want 0 0 0 00000013 00000000",
                 imem_req, valid_DX, count, inst_DX, PC_DX);
      end
      exp_q.delete();
      m_pc = 32'h200; m_pend = 0; m_disc = 0;
    end else begin
      n_cmp++;
      if (valid_DX !== (exp_q.size() != 0) || count !== 3'(exp_q.size())) begin
        n_bad++;
        $display("FAIL occupancy: got valid=%b count=%0d, want valid=%b count=%0d",
                 valid_DX, count, exp_q.size() != 0, exp_q.size());
      end
      exp_req = !redirect && ((exp_q.size() + int'(m_pend)) < 4);
      n_cmp++;
      if (imem_req !== exp_req) begin
        n_bad++;
        $display("FAIL issue_rule: got req=%b, want %b", imem_req, exp_req);
      end
      acc  = imem_req && !imem_wait;
      done = m_pend && !imem_wait;
      if (acc) begin
        n_cmp++;
        if (imem_addr !== m_pc) begin
          n_bad++;
          $display("FAIL fetch_addr: got %h, want %h", imem_addr, m_pc);
        end
      end
      if (valid_DX && !stall_DX) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL pop_empty: got pop of pc=%h, want no entry", PC_DX);
        end else begin
          head = exp_q.pop_front();
          if ({PC_DX, inst_DX} !== head) begin
            n_bad++;
            $display("FAIL pop_data: got pc=%h inst=%h, want pc=%h inst=%h",
                     PC_DX, inst_DX, head[63:32], head[31:0]);
          end
        end
      end
      if (redirect) begin
        exp_q.delete();
        if (m_pend && !done) m_disc = 1;
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      if (done) begin
        if (!m_disc && !redirect) exp_q.push_back({m_pend_addr, rdata_of(m_pend_addr)});
        m_pend = 0;
        m_disc = 0;
      end
      if (acc) begin
        m_pend = 1; m_disc = 0; m_pend_addr = imem_addr;
        acc_log.push_back(imem_addr);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hresetn = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_wait = 1'b0; stall_DX = 1'b0;
    cycle();
    cycle();
    hresetn = 1'b1;
    acc_log.delete();
  endtask

  task automatic test_reset();
    hresetn = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_wait = 1'b0; stall_DX = 1'b0;
    cycle();
    cycle();
    hresetn = 1'b1;
    acc_log.delete();
    cycle();
    n_cmp++;
    if (valid_DX !== 1'b0) begin
      n_bad++; $display("FAIL first_latency_early: got valid=%b, want 0", valid_DX);
    end
    cycle();
    n_cmp++;
    if (valid_DX !== 1'b1 || PC_DX !== 32'h200) begin
      n_bad++; $display("FAIL first_latency: got valid=%b pc=%h, want 1 00000200", valid_DX, PC_DX);
    end
    cycle();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (acc_log.size() < 3 || acc_log[i] !== 32'h200 + 32'(4*i)) begin
        n_bad++; $display("FAIL reset_seq_%0d: got %h, want %h", i, acc_log[i], 32'h200 + 32'(4*i));
      end
    end
    repeat (8) cycle();
  endtask

  task automatic test_fill();
    do_reset();
    stall_DX = 1'b1;
    repeat (12) cycle();
    n_cmp++;
    if (acc_log.size() != 4 || count !== 3'd4 || imem_req !== 1'b0) begin
      n_bad++; $display("FAIL fill_state: got accepts=%0d count=%0d req=%b, want 4 4 0", acc_log.size(), count, imem_req);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (acc_log[i] !== 32'h200 + 32'(4*i)) begin
        n_bad++; $display("FAIL fill_addr_%0d: got %h, want %h", i, acc_log[i], 32'h200 + 32'(4*i));
      end
    end
    repeat (10) cycle();
    n_cmp++;
    if (acc_log.size() != 4) begin
      n_bad++; $display("FAIL fill_hold: got accepts=%0d, want 4", acc_log.size());
    end
    stall_DX = 1'b0;
    cycle();
    stall_DX = 1'b1;
    n_cmp++;
    if (count !== 3'd3) begin
      n_bad++; $display("FAIL fill_pop_credit: got count=%0d, want 3", count);
    end
    cycle();
    n_cmp++;
    if (acc_log.size() != 5) begin
      n_bad++; $display("FAIL fill_resume_cnt: got accepts=%0d, want 5", acc_log.size());
    end else if (acc_log[4] !== 32'h210) begin
      n_bad++; $display("FAIL fill_resume: got %h, want 00000210", acc_log[4]);
    end
    stall_DX = 1'b0;
    repeat (8) cycle();
  endtask

  task automatic test_wait_states();
    do_reset();
    stall_DX = 1'b1;
    cycle();
    cycle();
    imem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (count !== 3'd1 || imem_addr !== 32'h208) begin
        n_bad++; $display("FAIL wait_hold_%0d: got count=%0d addr=%h, want 1 00000208", i, count, imem_addr);
      end
    end
    imem_wait = 1'b0;
    cycle();
    n_cmp++;
    if (count !== 3'd2 || acc_log.size() != 3) begin
      n_bad++; $display("FAIL wait_release: got count=%0d accepts=%0d, want 2 3", count, acc_log.size());
    end
    stall_DX = 1'b0;
    repeat (8) cycle();
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    stall_DX = 1'b1;
    repeat (3) cycle();
    imem_wait = 1'b1;
    cycle();
    redirect = 1'b1;
    redirect_pc = 32'h1003;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_bad++; $display("FAIL redirect_req: got %b, want 0", imem_req);
    end
    cycle();
    redirect = 1'b0;
    n_cmp++;
    if (count !== 3'd0 || valid_DX !== 1'b0) begin
      n_bad++; $display("FAIL redirect_flush: got count=%0d valid=%b, want 0 0", count, valid_DX);
    end
    cycle();
    imem_wait = 1'b0;
    cycle();
    n_cmp++;
    if (count !== 3'd0 || acc_log[acc_log.size()-1] !== 32'h1000) begin
      n_bad++; $display("FAIL redirect_drop: got count=%0d addr=%h, want 0 00001000", count, acc_log[acc_log.size()-1]);
    end
    cycle();
    n_cmp++;
    if (valid_DX !== 1'b1 || PC_DX !== 32'h1000 || inst_DX !== rdata_of(32'h1000)) begin
      n_bad++; $display("FAIL redirect_head: got valid=%b pc=%h inst=%h, want 1 00001000 %h",
                        valid_DX, PC_DX, inst_DX, rdata_of(32'h1000));
    end
    stall_DX = 1'b0;
    repeat (6) cycle();
  endtask

  task automatic test_pc_wrap();
    int n;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    n = acc_log.size();
    cycle();
    cycle();
    n_cmp++;
    if (acc_log.size() != n + 2) begin
      n_bad++; $display("FAIL wrap_cnt: got accepts=%0d, want %0d", acc_log.size(), n + 2);
    end else if (acc_log[n] !== 32'hFFFF_FFFC || acc_log[n+1] !== 32'h0) begin
      n_bad++; $display("FAIL wrap_addr: got %h %h, want fffffffc 00000000", acc_log[n], acc_log[n+1]);
    end
    repeat (4) cycle();
  endtask

  task automatic test_full_pop_push();
    do_reset();
    stall_DX = 1'b1;
    repeat (4) cycle();
    n_cmp++;
    if (count !== 3'd3 || imem_req !== 1'b0) begin
      n_bad++; $display("FAIL pp_setup: got count=%0d req=%b, want 3 0", count, imem_req);
    end
    stall_DX = 1'b0;
    cycle();
    n_cmp++;
    if (count !== 3'd3 || PC_DX !== 32'h204) begin
      n_bad++; $display("FAIL pp_count: got count=%0d pc=%h, want 3 00000204", count, PC_DX);
    end
    repeat (6) cycle();
  endtask

  task automatic test_async_reset();
    stall_DX = 1'b0;
    repeat (3) cycle();
    n_cmp++;
    if (valid_DX !== 1'b1 || imem_req !== 1'b1) begin
      n_bad++; $display("FAIL areset_pre: got valid=%b req=%b, want 1 1", valid_DX, imem_req);
    end
    #1;
    hresetn = 1'b0;
    #1;
    n_cmp++;
    if (valid_DX !== 1'b0 || imem_req !== 1'b0 || count !== 3'd0) begin
      n_bad++; $display("FAIL areset_now: got valid=%b req=%b count=%0d, want 0 0 0", valid_DX, imem_req, count);
    end
    cycle();
    hresetn = 1'b1;
    acc_log.delete();
    cycle();
    n_cmp++;
    if (acc_log.size() != 1 || acc_log[0] !== 32'h200) begin
      n_bad++; $display("FAIL areset_restart: got accepts=%0d addr=%h, want 1 00000200", acc_log.size(), acc_log[0]);
    end
    repeat (5) cycle();
  endtask

  initial begin
    hresetn = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_wait = 1'b0; stall_DX = 1'b0;
    imem_rdata = '0;
    m_pc = 32'h200; m_pend = 0; m_disc = 0; m_pend_addr = '0;
    test_reset();
    test_fill();
    test_wait_states();
    test_redirect_inflight();
    test_pc_wrap();
    test_full_pop_push();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
